rv_branch_predictor: RTL and testbench

Fetch-side dynamic branch predictor: the counterpart of the execute-stage branch test. It predicts taken/not-taken and target for a fetch PC, then learns from the resolved outcome the branch test produces. Per entry it keeps a valid bit, a partial tag, a target and a 2-bit saturating counter. It sits between the PC generator (lookup port) and the execute stage (update port).

---
 rtl/rv_bp_pkg.sv | 24 ++
 rtl/rv_bp_sat_counter.sv | 26 ++
 rtl/rv_branch_predictor.sv | 146 ++++++++++++++
 tb/tb_rv_branch_predictor.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_bp_pkg.sv
// rv_bp_pkg: shared constants for the fetch-side branch predictor.
// Holds the 2-bit counter encodings, the reset/allocation counter values
// and the PC slicing helpers used to form table index and tag.
package rv_bp_pkg;

    // Two-bit saturating counter encodings, ordered so bit 1 is the taken hint
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Counter value held by every entry after reset, and given to a new entry
    localparam logic [1:0] CTR_RESET = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    // Instructions are at least 4-byte aligned, so pc[1:0] never selects an entry
    localparam int IDX_LSB = 2;

    // The tag starts immediately above the index field
    function automatic int tag_lsb(input int idx_w);
        return idx_w + IDX_LSB;
    endfunction

endpackage

// File: rtl/rv_bp_sat_counter.sv
// rv_bp_sat_counter: next-state function of a 2-bit saturating counter.
// Taken moves towards strong-taken, not-taken towards strong-not-taken,
// and both ends hold their value instead of wrapping.
module rv_bp_sat_counter
    import rv_bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Step the counter one position in the resolved direction, saturating at the ends
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                ctr_next = ctr + 2'd1;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                ctr_next = ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/rv_branch_predictor.sv
// rv_branch_predictor: direct-mapped dynamic branch predictor.
// Each entry holds valid, partial tag, target and a 2-bit saturating counter.
// The lookup port answers one cycle later from registered outputs; the update
// port trains the table with resolved conditional branches from execute.
// Optional macro RV_BP_BYPASS_EN: forward a same-cycle update to the lookup
// of the same index; when undefined the lookup reads pre-update state.
// The PC must be wider than the index and tag fields combined.
module rv_branch_predictor
    import rv_bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 16,
    parameter int XLEN    = 64
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            pred_valid_i,
    input  logic [XLEN-1:0] pred_pc_i,
    output logic            pred_valid_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    input  logic            flush_i
);

    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int TAG_LSB = tag_lsb(IDX_W);
    localparam int TAG_MSB = TAG_LSB + TAG_W - 1;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] pred_tag;
    logic [TAG_W-1:0] upd_tag;

    logic             upd_hit;
    logic             upd_we;
    logic [1:0]       upd_ctr_step;
    logic [1:0]       new_ctr;
    logic [XLEN-1:0]  new_target;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [1:0]       rd_ctr;
    logic [XLEN-1:0]  rd_target;
    logic             lookup_taken;

    assign pred_idx = pred_pc_i[IDX_LSB +: IDX_W];
    assign upd_idx  = upd_pc_i[IDX_LSB +: IDX_W];
    assign pred_tag = pred_pc_i[TAG_LSB +: TAG_W];
    assign upd_tag  = upd_pc_i[TAG_LSB +: TAG_W];

    // Alignment bits, bits above the tag and the counter LSB carry no prediction information
    logic unused_bits;
    assign unused_bits = ^{pred_pc_i[IDX_LSB-1:0], pred_pc_i[XLEN-1:TAG_MSB+1],
                           upd_pc_i[IDX_LSB-1:0], upd_pc_i[XLEN-1:TAG_MSB+1], rd_ctr[0]};

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    rv_bp_sat_counter u_upd_ctr (
        .ctr      (ctr_q[upd_idx]),
        .taken    (upd_taken_i),
        .ctr_next (upd_ctr_step)
    );

    // Decide whether the resolved branch writes its entry and with what contents
    always_comb begin
        upd_we     = upd_valid_i && !flush_i && (upd_hit || upd_taken_i);
        new_ctr    = upd_hit ? upd_ctr_step : CTR_ALLOC;
        new_target = upd_taken_i ? upd_target_i : target_q[upd_idx];
    end

    // Table state: flush clears only valid bits and wins over a same-cycle update
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (upd_we) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= new_target;
            ctr_q[upd_idx]    <= new_ctr;
        end
    end

`ifdef RV_BP_BYPASS_EN
    logic [1:0] byp_ctr_step;

    rv_bp_sat_counter u_byp_ctr (
        .ctr      (ctr_q[pred_idx]),
        .taken    (upd_taken_i),
        .ctr_next (byp_ctr_step)
    );

    // Read the looked-up entry, substituting the post-update contents on an index collision
    always_comb begin
        rd_valid  = valid_q[pred_idx];
        rd_tag    = tag_q[pred_idx];
        rd_ctr    = ctr_q[pred_idx];
        rd_target = target_q[pred_idx];
        if (upd_we && (upd_idx == pred_idx)) begin
            rd_valid  = 1'b1;
            rd_tag    = upd_tag;
            rd_ctr    = upd_hit ? byp_ctr_step : CTR_ALLOC;
            rd_target = new_target;
        end
    end
`else
    // Read the looked-up entry as it stood before this cycle's update
    always_comb begin
        rd_valid  = valid_q[pred_idx];
        rd_tag    = tag_q[pred_idx];
        rd_ctr    = ctr_q[pred_idx];
        rd_target = target_q[pred_idx];
    end
`endif

    assign lookup_taken = pred_valid_i && rd_valid && (rd_tag == pred_tag) && rd_ctr[1];

    // Registered prediction; target is forced to zero whenever the prediction is not-taken
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pred_valid_o  <= 1'b0;
            pred_taken_o  <= 1'b0;
            pred_target_o <= '0;
        end else begin
            pred_valid_o  <= pred_valid_i;
            pred_taken_o  <= lookup_taken;
            pred_target_o <= lookup_taken ? rd_target : '0;
        end
    end

endmodule

// File: tb/tb_rv_branch_predictor.sv
// tb_rv_branch_predictor: self-checking bench for rv_branch_predictor.
// Directed vector table for the documented scenarios, randomized traffic
// against an abstract table model, and an asynchronous reset mid-stream.
// Honors RV_BP_BYPASS_EN for the same-cycle collision expectation.
module tb_rv_branch_predictor;

    localparam int NENT = 64;

    logic        clk;
    logic        rst_n;
    logic        pred_valid;
    logic [63:0] pred_pc;
    logic        pred_valid_out;
    logic        pred_taken_out;
    logic [63:0] pred_target_out;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic [63:0] upd_target;
    logic        flush;

    int checks = 0;
    int failures = 0;

    // Abstract model: one record per table slot, counter kept as an integer 0..3
    bit          m_valid  [NENT];
    logic [63:0] m_tag    [NENT];
    logic [63:0] m_target [NENT];
    int          m_ctr    [NENT];

    logic        exp_v;
    logic        exp_t;
    logic [63:0] exp_tgt;

    typedef struct {
        string       name;
        logic        pv;
        logic [63:0] pc;
        logic        uv;
        logic [63:0] upc;
        logic        ut;
        logic [63:0] utgt;
        logic        fl;
        logic        ev;
        logic        et;
        logic [63:0] etgt;
    } vec_t;

    vec_t vecs[$];

    rv_branch_predictor dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .pred_valid_i  (pred_valid),
        .pred_pc_i     (pred_pc),
        .pred_valid_o  (pred_valid_out),
        .pred_taken_o  (pred_taken_out),
        .pred_target_o (pred_target_out),
        .upd_valid_i   (upd_valid),
        .upd_pc_i      (upd_pc),
        .upd_taken_i   (upd_taken),
        .upd_target_i  (upd_target),
        .flush_i       (flush)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int slot_of(input logic [63:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction

    function automatic logic [63:0] tag_of(input logic [63:0] pc);
        return (pc >> 8) & 64'hFFFF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i]  = 1'b0;
            m_ctr[i]    = 1;
            m_target[i] = '0;
            m_tag[i]    = '0;
        end
    endtask

    task automatic model_lookup(input logic pv, input logic [63:0] pc,
                                output logic v, output logic t, output logic [63:0] tgt);
        int s;
        s = slot_of(pc);
        v = pv;
        t = 1'b0;
        tgt = '0;
        if (pv && m_valid[s] && m_tag[s] == tag_of(pc) && m_ctr[s] >= 2) begin
            t = 1'b1;
            tgt = m_target[s];
        end
    endtask

    task automatic model_update(input logic uv, input logic [63:0] upc, input logic ut,
                                input logic [63:0] utgt, input logic fl);
        int s;
        s = slot_of(upc);
        if (fl) begin
            for (int i = 0; i < NENT; i++) m_valid[i] = 1'b0;
        end else if (uv) begin
            if (m_valid[s] && m_tag[s] == tag_of(upc)) begin
                if (ut) begin
                    m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                    m_target[s] = utgt;
                end else begin
                    m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                end
            end else if (ut) begin
                m_valid[s]  = 1'b1;
                m_tag[s]    = tag_of(upc);
                m_target[s] = utgt;
                m_ctr[s]    = 2;
            end
        end
    endtask

    // Drive one cycle of inputs, predict the outcome with the model, and step past the edge
    task automatic applyStimulus(input logic pv, input logic [63:0] pc, input logic uv,
                                 input logic [63:0] upc, input logic ut,
                                 input logic [63:0] utgt, input logic fl);
        pred_valid = pv;
        pred_pc    = pc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utgt;
        flush      = fl;
`ifdef RV_BP_BYPASS_EN
        if (!fl) model_update(uv, upc, ut, utgt, fl);
        model_lookup(pv, pc, exp_v, exp_t, exp_tgt);
        if (fl) model_update(uv, upc, ut, utgt, fl);
`else
        model_lookup(pv, pc, exp_v, exp_t, exp_tgt);
        model_update(uv, upc, ut, utgt, fl);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic et,
                               input logic [63:0] etgt);
        checks++;
        if (pred_valid_out !== ev || pred_taken_out !== et || pred_target_out !== etgt) begin
            failures++;
            $display("[TB] FAIL %s: got valid=%0b taken=%0b target=%h, expected valid=%0b taken=%0b target=%h",
                     name, pred_valid_out, pred_taken_out, pred_target_out, ev, et, etgt);
        end
    endtask

    task automatic addVec(input string n, input logic pv, input logic [63:0] pc,
                          input logic uv, input logic [63:0] upc, input logic ut,
                          input logic [63:0] utgt, input logic fl,
                          input logic ev, input logic et, input logic [63:0] etgt);
        vec_t v;
        v.name = n; v.pv = pv; v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut;
        v.utgt = utgt; v.fl = fl; v.ev = ev; v.et = et; v.etgt = etgt;
        vecs.push_back(v);
    endtask

    function automatic logic [63:0] rand_pc();
        logic [63:0] p;
        p = {$urandom(), $urandom()};
        p[23:8] = 16'($urandom_range(0, 3));
        p[7:2]  = 6'($urandom_range(0, 7));
        return p;
    endfunction

    initial begin
        logic [63:0] pc_a;
        logic [63:0] pc_b;
        logic [63:0] tg;
        logic        coll_t;
        logic [63:0] coll_tgt;

        rst_n = 1'b1;
        pred_valid = 1'b0; pred_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        flush = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_state", 1'b0, 1'b0, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef RV_BP_BYPASS_EN
        coll_t = 1'b1; coll_tgt = 64'h6000;
`else
        coll_t = 1'b0; coll_tgt = 64'h0;
`endif

        //                name             pv  pc        uv  upc       ut  utgt      fl  ev  et  etgt
        addVec("cold_start",     1, 64'h1000, 0, 64'h0,    0, 64'h0,    0, 1, 0, 64'h0);
        addVec("alloc",          0, 64'h0,    1, 64'h1000, 1, 64'h2000, 0, 0, 0, 64'h0);
        addVec("alloc_lookup",   1, 64'h1000, 0, 64'h0,    0, 64'h0,    0, 1, 1, 64'h2000);
        addVec("train_t1",       1, 64'h1000, 1, 64'h1000, 1, 64'h2000, 0, 1, 1, 64'h2000);
        addVec("train_t2",       0, 64'h0,    1, 64'h1000, 1, 64'h2000, 0, 0, 0, 64'h0);
        addVec("nt_from_st",     1, 64'h1000, 1, 64'h1000, 0, 64'h0,    0, 1, 1, 64'h2000);
        addVec("weak_t_taken",   1, 64'h1000, 0, 64'h0,    0, 64'h0,    0, 1, 1, 64'h2000);
        addVec("nt_from_wt",     0, 64'h0,    1, 64'h1000, 0, 64'h0,    0, 0, 0, 64'h0);
        addVec("weak_nt",        1, 64'h1000, 0, 64'h0,    0, 64'h0,    0, 1, 0, 64'h0);
        addVec("retrain",        0, 64'h0,    1, 64'h1000, 1, 64'h2000, 0, 0, 0, 64'h0);
        addVec("nt_miss_upd",    0, 64'h0,    1, 64'h3000, 0, 64'h9999, 0, 0, 0, 64'h0);
        addVec("nt_miss_lookup", 1, 64'h3000, 0, 64'h0,    0, 64'h0,    0, 1, 0, 64'h0);
        addVec("nt_miss_intact", 1, 64'h1000, 0, 64'h0,    0, 64'h0,    0, 1, 1, 64'h2000);
        addVec("alias_alloc",    0, 64'h0,    1, 64'h1100, 1, 64'h4000, 0, 0, 0, 64'h0);
        addVec("alias_victim",   1, 64'h1000, 0, 64'h0,    0, 64'h0,    0, 1, 0, 64'h0);
        addVec("alias_owner",    1, 64'h1100, 0, 64'h0,    0, 64'h0,    0, 1, 1, 64'h4000);
        addVec("flush_cycle",    1, 64'h1100, 1, 64'h1000, 1, 64'h5000, 1, 1, 1, 64'h4000);
        addVec("flush_empty_a",  1, 64'h1100, 0, 64'h0,    0, 64'h0,    0, 1, 0, 64'h0);
        addVec("flush_drop_upd", 1, 64'h1000, 0, 64'h0,    0, 64'h0,    0, 1, 0, 64'h0);
        addVec("collision",      1, 64'h2040, 1, 64'h2040, 1, 64'h6000, 0, 1, coll_t, coll_tgt);
        addVec("after_collide",  1, 64'h2040, 0, 64'h0,    0, 64'h0,    0, 1, 1, 64'h6000);
        addVec("no_lookup",      0, 64'h2040, 0, 64'h0,    0, 64'h0,    0, 0, 0, 64'h0);
        addVec("pc_low_ignored", 1, 64'h2043, 0, 64'h0,    0, 64'h0,    0, 1, 1, 64'h6000);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].pv, vecs[i].pc, vecs[i].uv, vecs[i].upc,
                          vecs[i].ut, vecs[i].utgt, vecs[i].fl);
            checkOutput(vecs[i].name, vecs[i].ev, vecs[i].et, vecs[i].etgt);
        end

        // Random traffic on a small set of slots and tags so hits, aliasing and saturation recur
        for (int n = 0; n < 400; n++) begin
            pc_a = rand_pc();
            pc_b = ($urandom_range(0, 3) == 0) ? pc_a : rand_pc();
            tg = {$urandom(), $urandom()};
            applyStimulus(1'($urandom_range(0, 3) != 0), pc_a, 1'($urandom_range(0, 1)), pc_b,
                          1'($urandom_range(0, 9) < 6), tg, 1'($urandom_range(0, 31) == 0));
            checkOutput("random", exp_v, exp_t, exp_tgt);
        end

        // Train one entry hard, then pull reset between edges while an update is in flight
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 64'h0, 1'b1, 64'h1000, 1'b1, 64'h7000, 1'b0);
        end
        applyStimulus(1'b1, 64'h1000, 1'b1, 64'h1000, 1'b1, 64'h7000, 1'b0);
        checkOutput("pre_reset_taken", 1'b1, 1'b1, 64'h7000);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out", 1'b0, 1'b0, 64'h0);
        upd_valid = 1'b0;
        pred_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        checkOutput("reset_held", 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 64'h1000, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        checkOutput("post_reset_miss", 1'b1, 1'b0, 64'h0);
        for (int n = 0; n < 16; n++) begin
            applyStimulus(1'b1, rand_pc(), 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
            checkOutput("post_reset_rand", exp_v, exp_t, exp_tgt);
        end
        applyStimulus(1'b0, 64'h0, 1'b1, 64'h1000, 1'b1, 64'h8000, 1'b0);
        applyStimulus(1'b1, 64'h1000, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        checkOutput("post_reset_alloc", 1'b1, 1'b1, 64'h8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
